// File: rtl/data_mem_pkg.sv
// Shared types and default sizing for the
// latency-modelled data memory.
package data_mem_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LATENCY    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage: byte-enabled write port,
// asynchronous line-wide read port. Not reset.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int BYTES  = WORD_W / 8,
  localparam int BOFF_W = $clog2(BYTES),
  localparam int LOFF_W = $clog2(LINE_WORDS),
  localparam int WIDX_W = ADDR_W - BOFF_W,
  localparam int LIDX_W = WIDX_W - LOFF_W
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [WIDX_W-1:0]            i_waddr,
  input  logic [WORD_W-1:0]            i_wdata,
  input  logic [BYTES-1:0]             i_wbe,
  input  logic [LIDX_W-1:0]            i_raddr,
  output logic [WORD_W*LINE_WORDS-1:0] o_rdata
);

  localparam int DEPTH = 1 << WIDX_W;

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  for (genvar w = 0; w < LINE_WORDS; w++) begin : g_rd
    logic [WIDX_W-1:0] w_idx;
    assign w_idx = (WIDX_W'(i_raddr) << LOFF_W)
                 | WIDX_W'(w);
    assign o_rdata[w*WORD_W +: WORD_W] = r_mem[w_idx];
  end

endmodule

// File: rtl/data_mem_lat.sv
// Data memory with fixed access latency: word writes,
// line reads, one-cycle ready pulse per access.
module data_mem_lat
  import data_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         MemRead,
  input  logic                         MemWrite,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [WORD_W-1:0]            data_in,
  input  logic [WORD_W/8-1:0]          byte_en,
  output logic [WORD_W*LINE_WORDS-1:0] data_out,
  output logic                         ready,
  output logic                         busy
);

  localparam int BYTES  = WORD_W / 8;
  localparam int BOFF_W = $clog2(BYTES);
  localparam int LOFF_W = $clog2(LINE_WORDS);
  localparam int WIDX_W = ADDR_W - BOFF_W;
  localparam int LIDX_W = WIDX_W - LOFF_W;
  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int CNT_W  =
    (LATENCY < 2) ? 1 : $clog2(LATENCY);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(LATENCY - 1);
  localparam state_t ACC_STATE =
    (LATENCY > 1) ? S_WAIT : S_DONE;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wr;
  logic [WIDX_W-1:0]  r_widx;
  logic [WORD_W-1:0]  r_data;
  logic [BYTES-1:0]   r_be;
  logic [LINE_W-1:0]  r_line;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_accept;
  logic               w_is_idle;
  logic               w_enter_done;
  logic               w_op_wr;
  logic [WIDX_W-1:0]  w_op_widx;
  logic [WORD_W-1:0]  w_op_data;
  logic [BYTES-1:0]   w_op_be;
  logic               w_we;
  logic [LIDX_W-1:0]  w_raddr;
  logic [LINE_W-1:0]  w_rline;
  logic               w_unused_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ACC_STATE;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With LATENCY=1 the commit happens on the accept
  // edge itself, so the live inputs are used in IDLE.
  assign w_is_idle = (r_state == S_IDLE);
  assign w_op_wr   = w_is_idle ? MemWrite : r_wr;
  assign w_op_widx =
    w_is_idle ? addr[ADDR_W-1:BOFF_W] : r_widx;
  assign w_op_data = w_is_idle ? data_in : r_data;
  assign w_op_be   = w_is_idle ? byte_en : r_be;

  assign w_enter_done = (w_state_nxt == S_DONE)
                     && (r_state != S_DONE);
  assign w_we    = w_enter_done && w_op_wr;
  assign w_raddr = w_op_widx[WIDX_W-1:LOFF_W];

  assign w_unused_addr = ^addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_widx  <= '0;
      r_data  <= '0;
      r_be    <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_wr   <= MemWrite;
        r_widx <= addr[ADDR_W-1:BOFF_W];
        r_data <= data_in;
        r_be   <= byte_en;
      end
      if (w_enter_done && !w_op_wr) begin
        r_line <= w_rline;
      end
    end
  end

  data_mem_array #(
    .ADDR_W     (ADDR_W),
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_op_widx),
    .i_wdata (w_op_data),
    .i_wbe   (w_op_be),
    .i_raddr (w_raddr),
    .o_rdata (w_rline)
  );

  assign data_out = r_line;
  assign ready    = (r_state == S_DONE);
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_mem_lat.sv
// Directed bench for data_mem_lat: default build plus
// a LATENCY=1 / LINE_WORDS=8 build.
module tb_data_mem_lat;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rd_a = 1'b0, wr_a = 1'b0;
  logic rd_b = 1'b0, wr_b = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] din = '0;
  logic [3:0]  be = '0;
  logic [127:0] dout_a;
  logic [255:0] dout_b;
  logic rdy_a, busy_a, rdy_b, busy_b;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_lat dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemRead  (rd_a),
    .MemWrite (wr_a),
    .addr     (addr),
    .data_in  (din),
    .byte_en  (be),
    .data_out (dout_a),
    .ready    (rdy_a),
    .busy     (busy_a)
  );

  data_mem_lat #(
    .ADDR_W     (10),
    .WORD_W     (32),
    .LINE_WORDS (8),
    .LATENCY    (1)
  ) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemRead  (rd_b),
    .MemWrite (wr_b),
    .addr     (addr),
    .data_in  (din),
    .byte_en  (be),
    .data_out (dout_b),
    .ready    (rdy_b),
    .busy     (busy_b)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic access(input bit sel,
                        input bit rd,
                        input bit wr,
                        input logic [9:0] a,
                        input logic [31:0] d,
                        input logic [3:0] b,
                        input int exp_lat,
                        input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    addr = a;
    din = d;
    be = b;
    if (sel) begin
      rd_b = rd;
      wr_b = wr;
    end else begin
      rd_a = rd;
      wr_a = wr;
    end
    @(posedge clk);
    #1;
    rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if ((sel ? rdy_b : rdy_a) === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy@ready"},
        sel ? busy_b : busy_a, 1'b1);
    @(negedge clk);
    chk({tag, " ready pulse"},
        sel ? rdy_b : rdy_a, 1'b0);
    chk({tag, " busy after"},
        sel ? busy_b : busy_a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int n_rdy;
    int n_blo;
    int lat;
    logic [127:0] saved;

    #1 rst_n = 0;
    #1;
    chk("rst busy", busy_a, 1'b0);
    chk("rst ready", rdy_a, 1'b0);
    chk("rst dout", dout_a, '0);
    chk("rst dout b", dout_b, '0);
    @(negedge clk);
    rst_n = 1;

    access(0, 0, 1, 10'd4, 32'hCAFE, 4'hF, 4, "wr4");
    access(0, 1, 0, 10'd0, 32'h0, 4'h0, 4, "rd0");
    chk("rd0 w1", dout_a[63:32], 32'hCAFE);

    // reset two cycles into a write to word 1
    @(negedge clk);
    addr = 10'd5; din = 32'd8; be = 4'hF; wr_a = 1;
    @(posedge clk);
    #1 wr_a = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("midrst busy", busy_a, 1'b0);
    chk("midrst ready", rdy_a, 1'b0);
    chk("midrst dout", dout_a, '0);
    n_rdy = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdy_a) n_rdy++;
    end
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      if (rdy_a) n_rdy++;
    end
    chk("midrst no ready", n_rdy, 0);
    access(0, 1, 0, 10'd4, 32'h0, 4'h0, 4, "rd4");
    chk("midrst no commit", dout_a[63:32], 32'hCAFE);

    access(0, 0, 1, 10'd5, 32'd8, 4'hF, 4, "wr5");
    access(0, 1, 0, 10'd3, 32'h0, 4'h0, 4, "rd3");
    chk("raw w1", dout_a[63:32], 32'd8);

    access(0, 0, 1, 10'd16, 32'hAABBCCDD, 4'hF, 4,
           "wr16");
    access(0, 0, 1, 10'd18, 32'h11223344, 4'h5, 4,
           "wr18 be");
    access(0, 1, 0, 10'd28, 32'h0, 4'h0, 4, "rd28");
    chk("byte en", dout_a[31:0], 32'hAA22CC44);

    saved = dout_a;
    access(0, 1, 1, 10'd8, 32'h55, 4'hF, 4, "rdwr");
    chk("rdwr dout held", dout_a, saved);
    access(0, 1, 0, 10'd8, 32'h0, 4'h0, 4, "rd8");
    chk("rdwr w2", dout_a[95:64], 32'h55);
    chk("rdwr w1", dout_a[63:32], 32'd8);

    // inputs wiggled during WAIT must be ignored
    access(0, 0, 1, 10'h44, 32'h11, 4'hF, 4, "wr44");
    @(negedge clk);
    addr = 10'h40; din = 32'h77; be = 4'hF; wr_a = 1;
    @(posedge clk);
    #1 wr_a = 0;
    addr = 10'h44; din = 32'hDEAD; be = 4'hF;
    rd_a = 1;
    @(negedge clk);
    rd_a = 0;
    lat = 0;
    for (int n = 2; n <= 20; n++) begin
      @(negedge clk);
      if (rdy_a === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("mid latency", lat, 4);
    @(negedge clk);
    chk("mid no restart", busy_a, 1'b0);
    access(0, 1, 0, 10'h40, 32'h0, 4'h0, 4, "rd40");
    chk("mid w0", dout_a[31:0], 32'h77);
    chk("mid w1", dout_a[63:32], 32'h11);

    access(0, 0, 1, 10'd1020, 32'h99, 4'hF, 4, "wrtop");
    access(0, 1, 0, 10'd1023, 32'h0, 4'h0, 4, "rdtop");
    chk("top w3", dout_a[127:96], 32'h99);

    // level-held read: two back-to-back accesses
    @(negedge clk);
    addr = 10'd16;
    rd_a = 1;
    n_rdy = 0;
    n_blo = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (rdy_a) n_rdy++;
      if (i <= 9 && !busy_a) n_blo++;
      if (i == 10) rd_a = 0;
    end
    chk("held readies", n_rdy, 2);
    chk("held idle gap", n_blo, 1);
    chk("held data", dout_a[31:0], 32'hAA22CC44);

    access(1, 0, 1, 10'd36, 32'h9, 4'hF, 1, "b wr36");
    access(1, 0, 1, 10'd60, 32'hF, 4'hF, 1, "b wr60");
    access(1, 1, 0, 10'd47, 32'h0, 4'h0, 1, "b rd47");
    chk("b w1", dout_b[63:32], 32'h9);
    chk("b w7", dout_b[255:224], 32'hF);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
